// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared state encoding and sizing helpers for seq_chunk_adder
package seq_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk build still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - CHUNK-bit combinational ripple-carry slice
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
        co = w_c[CHUNK];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle WIDTH-bit add/sub reusing one CHUNK-bit slice
// Optional macro SEQ_ADD_EARLY_DONE_EN: finish early in add mode once the remaining chunks are zero.
module seq_chunk_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(NCHUNK);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_sub;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_acc_next;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_last;
    logic             w_early;
    logic             w_finish;
    logic             w_accept;

    assign w_b_eff = r_sub ? ~r_b : r_b;
    assign w_last  = (r_idx == IDXW'(NCHUNK - 1));

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = w_b_eff[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a  (w_a_chunk),
        .b  (w_b_chunk),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_acc_next[k*CHUNK +: CHUNK] = w_s;
            end
        end
    end

`ifdef SEQ_ADD_EARLY_DONE_EN
    logic w_rest_zero;

    always_comb begin
        w_rest_zero = 1'b1;
        for (int k = 0; k < NCHUNK; k++) begin
            if ((IDXW'(k) > r_idx) && ((r_a[k*CHUNK +: CHUNK] | r_b[k*CHUNK +: CHUNK]) != '0)) begin
                w_rest_zero = 1'b0;
            end
        end
    end

    // Accumulator is cleared on accept, so untouched upper chunks already read as zero.
    assign w_early = !r_sub && !w_co && w_rest_zero;
`else
    assign w_early = 1'b0;
`endif

    assign w_finish = (r_state == ST_RUN) && (w_last || w_early);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_finish) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub ? ~cin : cin;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_idx   <= r_idx + IDXW'(1);
            if (w_finish) begin
                r_sum  <= w_acc_next;
                r_cout <= w_co;
                r_ovf  <= (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4)
module tb_seq_chunk_adder;

`ifdef SEQ_ADD_EARLY_DONE_EN
    localparam int L_T1   = 1;
    localparam int L_SMALL = 1;
    localparam int L_CARRY = 3;
`else
    localparam int L_T1   = 4;
    localparam int L_SMALL = 4;
    localparam int L_CARRY = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                mon_e = q.pop_front();
                chk({mon_e.name, "_sum"},  32'(sum),  32'(mon_e.sum));
                chk({mon_e.name, "_cout"}, 32'(cout), 32'(mon_e.cout));
                chk({mon_e.name, "_ovf"},  32'(ovf),  32'(mon_e.ovf));
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
            end
        end
    end

    // Called at a falling edge; the following rising edge samples start.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                         input logic isub, input logic [15:0] es, input logic ec,
                         input logic eo, input int lat, input string nm);
        exp_t e;
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        start = 1'b1;
        e.sum = es;
        e.cout = ec;
        e.ovf = eo;
        e.start_cyc = cyc + 1;
        e.lat = lat;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic wait_done(input string nm, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done", nm);
        end
    endtask

    task automatic op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                      input logic isub, input logic [15:0] es, input logic ec,
                      input logic eo, input int lat, input string nm, output int busy_cnt);
        issue(ia, ib, icin, isub, es, ec, eo, lat, nm);
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, busy_cnt);
        @(negedge clk);
    endtask

    initial begin
        int bc;
        int done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum",  32'(sum),  0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf",  32'(ovf),  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, L_T1, "t1", bc);
        chk("t1_busy_cycles", 32'(bc), 32'(L_T1));
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "t2a", bc);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "t2b", bc);
        op(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 4, "t3a", bc);
        op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "t3b", bc);
        chk("t3b_busy_cycles", 32'(bc), 4);
        op(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 4, "add_cin", bc);
        op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1, 4, "sub_borrow_ovf", bc);

        // start ignored in RUN, then back-to-back accept on the DONE cycle
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "t4a");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4a", bc);
        issue(16'hA000, 16'h6000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "t4b");
        @(negedge clk);
        start = 1'b0;
        wait_done("t4b", bc);
        @(negedge clk);

        op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1, 4, "pre_rst", bc);
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_sum",  32'(sum),  0);
        chk("t5_cout", 32'(cout), 0);
        chk("t5_ovf",  32'(ovf),  0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("t5_no_done_after_abort", 32'(done_seen), 0);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, L_CARRY, "t5_after", bc);

        op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, L_SMALL, "t6a", bc);
        op(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, L_CARRY, "t6b", bc);
        op(16'h0002, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 4, "t6_sub", bc);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor that generalises the team's 4-bit ripple carry adder to WIDTH bits.
- Processes CHUNK bits per clock through one CHUNK-bit ripple slice, carrying between cycles in a register.
- Uses a start/busy/done handshake.
- Sits in datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled on rising clk.
- sub  in  1  0: A+B+cin; 1: A−B−cin (cin acts as borrow-in).
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry/borrow in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held until next completion.
- cout  out  1  final carry out. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow of the final result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0; done=0; sum=0; cout=0; ovf=0; internal carry and chunk index = 0.
- States and transitions:
  - IDLE: start=1 → latch a, b, cin, sub; go to RUN with idx=0.
  - RUN: each cycle, slice idx is added.
    - B operand is b, or ~b when sub=1.
    - Carry into chunk 0 is cin, or !cin when sub=1.
    - Chunk result is written to an internal accumulator; carry is registered for the next chunk; idx increments.
    - idx=NCHUNK−1 → go to DONE.
  - DONE: lasts one cycle.
    - sum, cout, ovf update on the edge entering DONE; done=1 for that cycle.
    - Then go to IDLE, or back to RUN if start=1 in that cycle (back-to-back accepted).
- Latency: done is high in the cycle after the NCHUNK-th rising edge following the edge that sampled start. Default NCHUNK=4.
- busy=1 exactly in RUN; start is ignored while in RUN (no queueing).
- sum/cout/ovf remain stable during RUN; they only change on entering DONE.
- ovf = (A_msb == Beff_msb) && (sum_msb != A_msb), where Beff is B after the sub inversion.
- NCHUNK=1: RUN lasts one cycle; the rules are otherwise unchanged.
- rst_n low mid-operation: aborts immediately. Outputs return to reset values and no done is produced.

Optional Feature:
SEQ_ADD_EARLY_DONE_EN
- Defined: in add mode only (sub=0), when in RUN the registered carry is 0 and all remaining unprocessed chunks of A and B are zero:
  - the remaining sum bits are written as 0;
  - cout=0 and ovf=0;
  - the FSM goes directly to DONE.
  - Latency becomes data-dependent, between 1 and NCHUNK cycles.
  - The check is on chunks idx+1..NCHUNK−1 after the current chunk is added.
- Undefined: fixed NCHUNK-cycle latency in all modes.
- Sub mode always uses the fixed latency.

Decomposition:
- Shared package seq_add_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - helper for NCHUNK and index width (clog2).
- Sub-module chunk_adder: CHUNK-bit combinational ripple slice with ports a, b, ci, s, co. It is instantiated once; the sequential top reuses it every cycle.

Test Plan (WIDTH=16, CHUNK=4, macro undefined unless stated):
1. a=0x0001, b=0x0000, cin=0, sub=0 → sum=0x0001, cout=0, ovf=0; done exactly 4 cycles after start; busy high for 4 cycles.
2. a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
3. sub=1, a=0x0005, b=0x0003, cin=0 → sum=0x0002, cout=1. Then a=0x0003, b=0x0005 → sum=0xFFFE, cout=0, ovf=0.
4. start pulsed during RUN with different operands → ignored; result is from the first operands. start held on the DONE cycle → second operation accepted; its done arrives 4 cycles later.
5. rst_n pulled low at RUN cycle 2 → busy, done, sum, cout, ovf go to 0 asynchronously; no done pulse after release; the next start completes normally.
6. With SEQ_ADD_EARLY_DONE_EN: a=0x0001, b=0x0002 → sum=0x0003, done 1 cycle after start. a=0x00F0, b=0x0010 → sum=0x0100, done 3 cycles after start (chunk 1 carries into chunk 2). Sub-mode operations still take 4 cycles.
